// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcodes, FSM states and operand register addresses shared by sys_ctrl
package sys_ctrl_pkg;
  localparam int OP_RF_WR = 'hAA;
  localparam int OP_RF_RD = 'hBB;
  localparam int OP_ALU = 'hCC;
  localparam int OP_ALU_NOP = 'hDD;
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI
  } stateT;
endpackage

// File: rtl/sys_ctrl_wdt.sv
// sys_ctrl_wdt: wait-timeout counter (CLK, RST, clr zeroes, en counts, expired at WAIT_TIMEOUT)
module sys_ctrl_wdt #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK)
    cnt <= (RST || clr) ? '0 : (en && !expired) ? cnt + CW'(1) : cnt;
  assign expired = cnt == CW'(WAIT_TIMEOUT);
endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes RX command frames into register-file writes/reads and ALU ops, returns results as TX bytes
// Inputs: RX_P_DATA/RX_D_VLD byte stream, RdData/RdData_Valid, ALU_OUT/ALU_OUT_Valid, FIFO_FULL.
// Outputs (all registered): Address/WrData/WrEn/RdEn to RF, ALU_FUN/ALU_EN/CLK_GATE_EN to ALU, TX_P_DATA/TX_D_VLD to FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int ADDR = 4,
  parameter int WIDTH = 8,
  parameter int ALU_FUN_W = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [WIDTH-1:0]     RdData,
  input  logic                 RdData_Valid,
  input  logic [2*WIDTH-1:0]   ALU_OUT,
  input  logic                 ALU_OUT_Valid,
  input  logic                 FIFO_FULL,
  output logic [ADDR-1:0]      Address,
  output logic [WIDTH-1:0]     WrData,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ALU_FUN_W-1:0] ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_GATE_EN,
  output logic [WIDTH-1:0]     TX_P_DATA,
  output logic                 TX_D_VLD
);
  stateT state, nextState;
  logic [WIDTH-1:0] rdByte;
  logic [2*WIDTH-1:0] aluRes;
  logic wrNext, rdNext, aluEnNext, txNext;
  logic [ADDR-1:0] addrNext;
  logic [WIDTH-1:0] wrDataNext, txDataNext;
  logic [ALU_FUN_W-1:0] funNext;
  logic waiting, wdtExpired;

  assign waiting = state == RD_WAIT || state == ALU_WAIT;

  sys_ctrl_wdt #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) wdt (
    .CLK(CLK),
    .RST(RST),
    .clr(!waiting),
    .en(waiting),
    .expired(wdtExpired)
  );

  always_comb begin
    nextState = state;
    wrNext = 1'b0;
    rdNext = 1'b0;
    aluEnNext = 1'b0;
    txNext = 1'b0;
    addrNext = Address;
    wrDataNext = WrData;
    txDataNext = TX_P_DATA;
    funNext = ALU_FUN;
    case (state)
      IDLE: nextState = !RX_D_VLD ? IDLE :
                        RX_P_DATA == WIDTH'(OP_RF_WR) ? WR_ADDR :
                        RX_P_DATA == WIDTH'(OP_RF_RD) ? RD_ADDR :
                        RX_P_DATA == WIDTH'(OP_ALU) ? OPA :
                        RX_P_DATA == WIDTH'(OP_ALU_NOP) ? FUN : IDLE;
      WR_ADDR: if (RX_D_VLD) begin
        addrNext = RX_P_DATA[ADDR-1:0];
        nextState = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wrNext = 1'b1;
        wrDataNext = RX_P_DATA;
        nextState = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rdNext = 1'b1;
        addrNext = RX_P_DATA[ADDR-1:0];
        nextState = RD_WAIT;
      end
      RD_WAIT: nextState = RdData_Valid ? TX_RD : wdtExpired ? IDLE : RD_WAIT;
      OPA: if (RX_D_VLD) begin
        wrNext = 1'b1;
        addrNext = ADDR'(OPA_ADDR);
        wrDataNext = RX_P_DATA;
        nextState = OPB;
      end
      OPB: if (RX_D_VLD) begin
        wrNext = 1'b1;
        addrNext = ADDR'(OPB_ADDR);
        wrDataNext = RX_P_DATA;
        nextState = FUN;
      end
      FUN: if (RX_D_VLD) begin
        aluEnNext = 1'b1;
        funNext = RX_P_DATA[ALU_FUN_W-1:0];
        nextState = ALU_WAIT;
      end
      ALU_WAIT: nextState = ALU_OUT_Valid ? TX_LO : wdtExpired ? IDLE : ALU_WAIT;
      TX_RD: if (!FIFO_FULL) begin
        txNext = 1'b1;
        txDataNext = rdByte;
        nextState = IDLE;
      end
      TX_LO: if (!FIFO_FULL) begin
        txNext = 1'b1;
        txDataNext = aluRes[WIDTH-1:0];
        nextState = TX_HI;
      end
      // the low-byte push is still on TX_D_VLD here, so wait for it to drop to keep the pulses separate
      TX_HI: if (!FIFO_FULL && !TX_D_VLD) begin
        txNext = 1'b1;
        txDataNext = aluRes[2*WIDTH-1:WIDTH];
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rdByte <= '0;
      aluRes <= '0;
      Address <= '0;
      WrData <= '0;
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      ALU_FUN <= '0;
      ALU_EN <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD <= 1'b0;
    end else begin
      state <= nextState;
      rdByte <= (state == RD_WAIT && RdData_Valid) ? RdData : rdByte;
      aluRes <= (state == ALU_WAIT && ALU_OUT_Valid) ? ALU_OUT : aluRes;
      Address <= addrNext;
      WrData <= wrDataNext;
      WrEn <= wrNext;
      RdEn <= rdNext;
      ALU_FUN <= funNext;
      ALU_EN <= aluEnNext;
      CLK_GATE_EN <= nextState == ALU_WAIT;
      TX_P_DATA <= txDataNext;
      TX_D_VLD <= txNext;
    end
  end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: scoreboard bench for sys_ctrl with RF/ALU responders and FIFO backpressure
module tb_sys_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic RX_D_VLD = 1'b0;
  logic [7:0] RdData = '0;
  logic RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic ALU_OUT_Valid = 1'b0;
  logic FIFO_FULL = 1'b0;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic WrEn, RdEn;
  logic [3:0] ALU_FUN;
  logic ALU_EN, CLK_GATE_EN;
  logic [7:0] TX_P_DATA;
  logic TX_D_VLD;

  always #5 CLK = ~CLK;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .FIFO_FULL(FIFO_FULL), .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  int nTests = 0;
  int nFail = 0;
  logic [11:0] wrQ[$];
  logic [3:0] rdQ[$];
  logic [3:0] aluQ[$];
  logic [7:0] txQ[$];
  logic [7:0] mem [16] = '{default: 8'h00};
  logic txAllowed = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    nTests++;
    nFail++;
    $display("FAIL %s: strobe seen, none expected", name);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (wrQ.size() + rdQ.size() + aluQ.size() + txQ.size()) != 0; i++) tick();
    check(name, wrQ.size() + rdQ.size() + aluQ.size() + txQ.size(), 0);
  endtask

  always @(posedge CLK) if (WrEn) mem[Address] <= WrData;

  initial forever begin
    @(negedge CLK);
    if (RdEn) begin
      repeat (2) @(posedge CLK);
      #1;
      RdData = mem[Address];
      RdData_Valid = 1'b1;
      @(posedge CLK);
      #1;
      RdData_Valid = 1'b0;
    end
  end

  always @(negedge CLK) if (!RST) begin
    if (WrEn) begin
      if (wrQ.size() != 0) check("wr", {Address, WrData, RdEn, ALU_EN}, {wrQ.pop_front(), 2'b00});
      else unexpected("wr");
    end
    if (RdEn) begin
      if (rdQ.size() != 0) check("rd", {Address, WrEn}, {rdQ.pop_front(), 1'b0});
      else unexpected("rd");
    end
    if (ALU_EN) begin
      if (aluQ.size() != 0) check("alu_en", {ALU_FUN, CLK_GATE_EN, WrEn}, {aluQ.pop_front(), 2'b10});
      else unexpected("alu_en");
    end
    if (TX_D_VLD) begin
      if (txQ.size() != 0) check("tx", {TX_P_DATA, txAllowed}, {txQ.pop_front(), 1'b1});
      else unexpected("tx");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("reset_outputs", {Address, WrData, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
    RST = 1'b0;
    tick();

    wrQ.push_back({4'h5, 8'h0A});
    sendByte(8'hAA); sendByte(8'h05); sendByte(8'h0A);
    drain("rf_write_done");

    rdQ.push_back(4'h5);
    txQ.push_back(8'h0A);
    sendByte(8'hBB); sendByte(8'h05);
    drain("rf_read_done");

    wrQ.push_back({4'h0, 8'h03});
    wrQ.push_back({4'h1, 8'h04});
    aluQ.push_back(4'h0);
    txQ.push_back(8'h07);
    txQ.push_back(8'h00);
    sendByte(8'hCC); sendByte(8'h03); sendByte(8'h04); sendByte(8'h00);
    for (int i = 0; i < 10 && !ALU_EN; i++) tick();
    check("alu_en_seen", ALU_EN, 1);
    tick(); tick();
    check("cg_wait", CLK_GATE_EN, 1);
    ALU_OUT = 16'h0007;
    ALU_OUT_Valid = 1'b1;
    FIFO_FULL = 1'b1;
    txAllowed = 1'b0;
    check("cg_valid_cycle", CLK_GATE_EN, 1);
    tick();
    ALU_OUT_Valid = 1'b0;
    check("cg_after_valid", CLK_GATE_EN, 0);
    repeat (4) tick();
    FIFO_FULL = 1'b0;
    txAllowed = 1'b1;
    drain("alu_op_done");

    aluQ.push_back(4'h2);
    sendByte(8'hDD); sendByte(8'h02);
    check("nop_alu_en", ALU_EN, 1);
    repeat (16) tick();
    check("cg_before_timeout", CLK_GATE_EN, 1);
    tick();
    check("cg_after_timeout", CLK_GATE_EN, 0);
    repeat (5) tick();
    drain("nop_timeout_done");

    sendByte(8'h55);
    sendByte(8'hAA); sendByte(8'h02);
    RST = 1'b1;
    tick();
    check("rst_mid_outputs", {Address, WrData, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
    RST = 1'b0;
    tick();
    sendByte(8'h09);
    repeat (3) tick();
    wrQ.push_back({4'h3, 8'h0C});
    sendByte(8'hAA); sendByte(8'h13); sendByte(8'h0C);
    drain("robust_done");

    rdQ.push_back(4'h5);
    txQ.push_back(8'h0A);
    sendByte(8'hBB); sendByte(8'h05);
    sendByte(8'hAA); sendByte(8'h07); sendByte(8'h0C);
    drain("rd_wait_drop_done");
    repeat (5) tick();
    check("mem_addr7_untouched", mem[7], 8'h00);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command-decoding controller that sits directly upstream of Register_File and the ALU in the system clock domain.
- Consumes parallel bytes from the UART RX path and turns framed commands into register-file write/read strobes and ALU operations.
- Returns read data and ALU results as bytes to the TX-side FIFO.

Parameters:
- ADDR, 4, register-file address width
- WIDTH, 8, data/byte width
- ALU_FUN_W, 4, ALU function code width
- WAIT_TIMEOUT, 16, max cycles to wait for RdData_Valid / ALU_OUT_Valid before aborting to IDLE

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous and active-high
- RX_P_DATA  in  WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- RdData  in  WIDTH  register-file read data
- RdData_Valid  in  1  register-file read data valid
- ALU_OUT  in  2*WIDTH  ALU result
- ALU_OUT_Valid  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO cannot accept a byte
- Address  out  ADDR  register-file address
- WrData  out  WIDTH  register-file write data
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- ALU_FUN  out  ALU_FUN_W  ALU operation select
- ALU_EN  out  1  ALU start strobe
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle push strobe to TX FIFO

Behaviour:
- Clocking and reset: single clock CLK. Synchronous active-high RST. All outputs are registered and reset to 0. State resets to IDLE, the timeout counter resets to 0, and all latches reset to 0.
- RST asserted mid-command abandons that command with no further strobes. A partial frame is discarded.
- Opcodes, taken from the first byte received in IDLE:
  - 0xAA RF_WR: frame is addr, data.
  - 0xBB RF_RD: frame is addr.
  - 0xCC ALU_OP: frame is opA, opB, fun.
  - 0xDD ALU_NOP: frame is fun.
  - Any other byte in IDLE is ignored and the block stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- Frame capture: only RX_D_VLD advances frame capture. Bytes arriving in RD_WAIT, ALU_WAIT or the TX_* states are dropped.
- Addresses: address bytes use bits [ADDR-1:0]; upper bits are ignored.
- RF_WR: the cycle after the data byte, WrEn=1, Address=latched addr, WrData=byte, for exactly one cycle. Then IDLE.
- RF_RD:
  - The cycle after the addr byte: RdEn=1, Address=addr for one cycle, then RD_WAIT.
  - On RdData_Valid, latch RdData and go to TX_RD.
  - In TX_RD, on the first cycle with FIFO_FULL=0: TX_P_DATA=latched byte, TX_D_VLD=1 for one cycle, then IDLE.
- ALU_OP:
  - opA is written to RF address 0 and opB to RF address 1, each as a one-cycle WrEn pulse on the cycle after its byte.
  - On the fun byte: ALU_FUN=fun[ALU_FUN_W-1:0] and ALU_EN=1 for one cycle, then ALU_WAIT.
- ALU_NOP: same as ALU_OP from the fun byte onward, with no RF writes.
- CLK_GATE_EN is 1 from the ALU_EN cycle through the cycle ALU_OUT_Valid is sampled, and 0 otherwise.
- ALU result: on ALU_OUT_Valid, latch ALU_OUT. TX_LO sends ALU_OUT[7:0], then TX_HI sends ALU_OUT[15:8]. Each byte waits for FIFO_FULL=0 and gets its own one-cycle TX_D_VLD, so the two pushes are at least one cycle apart. Then IDLE.
- Timeout: the counter runs only in RD_WAIT and ALU_WAIT and clears on entry. When it reaches WAIT_TIMEOUT with no valid, the block returns to IDLE, emits nothing and deasserts CLK_GATE_EN.
- Simultaneous events:
  - A valid and the timeout in the same cycle: valid wins.
  - FIFO_FULL may stay high indefinitely in TX states; no timeout applies there.
- WrEn and RdEn are never both 1. ALU_EN never coincides with WrEn.

Decomposition:
- Package sys_ctrl_pkg: opcode constants (0xAA, 0xBB, 0xCC, 0xDD), state enum, operand RF addresses (OPA_ADDR=0, OPB_ADDR=1).
- Sub-module sys_ctrl_wdt: wait-timeout counter with clear/enable inputs and an expired output, parameterised by WAIT_TIMEOUT.

Test Plan:
- RF write: RX bytes 0xAA, 0x05, 0x0A -> one WrEn pulse with Address=5, WrData=0x0A. No RdEn and no TX_D_VLD.
- RF read: RX 0xBB, 0x05. Model returns RdData=0x0A with RdData_Valid 2 cycles after RdEn -> one RdEn pulse with Address=5, then TX_P_DATA=0x0A with TX_D_VLD.
- ALU op with backpressure: RX 0xCC, 0x03, 0x04, 0x00. FIFO_FULL=1 for 5 cycles after ALU_OUT=0x0007 is valid:
  - WrEn pulses at addr 0 (0x03) and addr 1 (0x04), then ALU_EN with ALU_FUN=0.
  - CLK_GATE_EN=1 during the wait.
  - TX bytes 0x07 then 0x00, issued only after FIFO_FULL falls.
- ALU NOP timeout: RX 0xDD, 0x02 with no ALU_OUT_Valid -> ALU_EN pulse. After WAIT_TIMEOUT cycles the block is back in IDLE, CLK_GATE_EN=0, no TX.
- Robustness: RX 0x55 in IDLE -> ignored. Then RX 0xAA, 0x02, with RST pulsed before the data byte, then RX 0x09 -> no WrEn, and 0x09 is treated as an unknown opcode.
- RX bytes during RD_WAIT are dropped and the read completes normally.
